// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-back controller for the 32x32 register file.
//   - Arbitrates ALU, LSU (load return) and debug writes onto the single
//     regfile write port. The grant is combinational and the write reaches
//     the regfile one cycle later.
//   - Keeps a busy scoreboard of pending destinations and reports RAW
//     hazards and WAW stalls to the issue logic.
//
// Optional feature macro: WB_BYPASS_EN
//   When it is defined, the write currently on rf_* is forwarded to the
//   issue sources. A forwarded source does not raise hazard_o.
//
// Ports:
//   clk_i, rst_n_i               clock, asynchronous active-low reset
//   flush_i                      clears the scoreboard and drops the pending write
//   issue_*                      issue request, destination and sources
//   issue_ready_o, hazard_o      issue accepted / RAW hazard on a source
//   alu_*, lsu_*, dbg_*          write requesters (valid/rd/data) and grants
//   rf_enable_o, rf_reg_write_o  regfile enable and write strobe
//   rf_rd_o, rf_wdata_o          regfile write address and data
//   err_o                        sticky: ALU/LSU wrote to a register that was not busy
//   fwd{1,2}_valid_o/_data_o     forwarding to the issue sources (WB_BYPASS_EN only)
module regfile_wb_ctrl #(
    parameter int STARVE_LIM = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flush_i,
    input  logic        issue_valid_i,
    input  logic        issue_wr_i,
    input  logic [4:0]  issue_rd_i,
    input  logic [4:0]  issue_rs1_i,
    input  logic [4:0]  issue_rs2_i,
    output logic        issue_ready_o,
    output logic        hazard_o,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    output logic        alu_ready_o,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_ready_o,
    input  logic        dbg_valid_i,
    input  logic [4:0]  dbg_rd_i,
    input  logic [31:0] dbg_data_i,
    output logic        dbg_ready_o,
    output logic        rf_enable_o,
    output logic        rf_reg_write_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_wdata_o,
    output logic        err_o
`ifdef WB_BYPASS_EN
    ,
    output logic        fwd1_valid_o,
    output logic [31:0] fwd1_data_o,
    output logic        fwd2_valid_o,
    output logic [31:0] fwd2_data_o
`endif
);

    logic [31:0]      busy_q, busy_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             rf_en_q, rf_en_d;
    logic             rf_we_q, rf_we_d;
    logic             wb_sb_q, wb_sb_d;   // write on rf_* came from ALU/LSU
    logic [4:0]       rf_rd_q, rf_rd_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic             err_q, err_d;

    logic src1_act, src2_act, rd_act, dbg_rd_act;
    logic src1_haz, src2_haz;
    logic lsu_prio, alu_gnt, lsu_gnt, dbg_gnt, gnt_any, gnt_sb;
    logic [4:0]  gnt_rd;
    logic [31:0] gnt_data;

    // A register is active when it is non-zero and still owes a write-back.
    function automatic logic active(input logic [4:0] r, input logic [31:0] b);
        return (r != 5'd0) && b[r];
    endfunction

    assign src1_act   = active(issue_rs1_i, busy_q);
    assign src2_act   = active(issue_rs2_i, busy_q);
    assign rd_act     = active(issue_rd_i, busy_q);
    assign dbg_rd_act = active(dbg_rd_i, busy_q);

`ifdef WB_BYPASS_EN
    assign fwd1_valid_o = rf_we_q && (rf_rd_q == issue_rs1_i) && (issue_rs1_i != 5'd0);
    assign fwd2_valid_o = rf_we_q && (rf_rd_q == issue_rs2_i) && (issue_rs2_i != 5'd0);
    assign fwd1_data_o  = rf_wdata_q;
    assign fwd2_data_o  = rf_wdata_q;
    assign src1_haz     = src1_act && !fwd1_valid_o;
    assign src2_haz     = src2_act && !fwd2_valid_o;
`else
    assign src1_haz     = src1_act;
    assign src2_haz     = src2_act;
`endif

    assign hazard_o      = issue_valid_i && (src1_haz || src2_haz);
    // A busy destination is a WAW stall.
    assign issue_ready_o = issue_valid_i && !flush_i && !hazard_o &&
                           !(issue_wr_i && rd_act);

    // LSU overtakes ALU once it has waited STARVE_LIM cycles.
    assign lsu_prio = (starve_q == CNT_W'(STARVE_LIM));
    assign alu_gnt  = alu_valid_i && !flush_i && !(lsu_prio && lsu_valid_i);
    assign lsu_gnt  = lsu_valid_i && !flush_i && (lsu_prio || !alu_valid_i);
    assign dbg_gnt  = dbg_valid_i && !flush_i && !alu_valid_i && !lsu_valid_i &&
                      !dbg_rd_act;
    assign gnt_any  = alu_gnt || lsu_gnt || dbg_gnt;
    assign gnt_sb   = alu_gnt || lsu_gnt;

    assign alu_ready_o = alu_gnt;
    assign lsu_ready_o = lsu_gnt;
    assign dbg_ready_o = dbg_gnt;

    always_comb begin
        gnt_rd   = dbg_rd_i;
        gnt_data = dbg_data_i;
        if (alu_gnt) begin
            gnt_rd   = alu_rd_i;
            gnt_data = alu_data_i;
        end else if (lsu_gnt) begin
            gnt_rd   = lsu_rd_i;
            gnt_data = lsu_data_i;
        end
    end

    always_comb begin
        rf_en_d    = gnt_any;
        rf_we_d    = gnt_any && (gnt_rd != 5'd0);
        wb_sb_d    = gnt_sb;
        rf_rd_d    = gnt_any ? gnt_rd : rf_rd_q;
        rf_wdata_d = gnt_any ? gnt_data : rf_wdata_q;
        err_d      = err_q || (gnt_sb && (gnt_rd != 5'd0) && !busy_q[gnt_rd]);

        // Clear on the edge the regfile captures the data; a set on the
        // same index is applied afterwards so it wins.
        busy_d = busy_q;
        if (rf_we_q && wb_sb_q)
            busy_d[rf_rd_q] = 1'b0;
        if (issue_ready_o && issue_wr_i && (issue_rd_i != 5'd0))
            busy_d[issue_rd_i] = 1'b1;
        if (flush_i)
            busy_d = '0;
        busy_d[0] = 1'b0;

        starve_d = starve_q;
        if (flush_i || !lsu_valid_i || lsu_gnt)
            starve_d = '0;
        else if (!lsu_prio)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q     <= '0;
            starve_q   <= '0;
            rf_en_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            wb_sb_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            starve_q   <= starve_d;
            rf_en_q    <= rf_en_d;
            rf_we_q    <= rf_we_d;
            wb_sb_q    <= wb_sb_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    assign rf_enable_o    = rf_en_q;
    assign rf_reg_write_o = rf_we_q;
    assign rf_rd_o        = rf_rd_q;
    assign rf_wdata_o     = rf_wdata_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Testbench for regfile_wb_ctrl: a table of single-cycle grant/hazard
// vectors applied against a known scoreboard, plus directed multi-cycle
// sequences for write-back latency, starvation, debug blocking, flush,
// sticky error and asynchronous reset.
module tb_regfile_wb_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        issue_valid_i, issue_wr_i;
    logic [4:0]  issue_rd_i, issue_rs1_i, issue_rs2_i;
    logic        issue_ready_o, hazard_o;
    logic        alu_valid_i, lsu_valid_i, dbg_valid_i;
    logic [4:0]  alu_rd_i, lsu_rd_i, dbg_rd_i;
    logic [31:0] alu_data_i, lsu_data_i, dbg_data_i;
    logic        alu_ready_o, lsu_ready_o, dbg_ready_o;
    logic        rf_enable_o, rf_reg_write_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_wdata_o;
    logic        err_o;
`ifdef WB_BYPASS_EN
    logic        fwd1_valid_o, fwd2_valid_o;
    logic [31:0] fwd1_data_o, fwd2_data_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    regfile_wb_ctrl #(.STARVE_LIM(4), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_wr_i(issue_wr_i),
        .issue_rd_i(issue_rd_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_ready_o(issue_ready_o), .hazard_o(hazard_o),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .alu_ready_o(alu_ready_o),
        .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .lsu_ready_o(lsu_ready_o),
        .dbg_valid_i(dbg_valid_i), .dbg_rd_i(dbg_rd_i), .dbg_data_i(dbg_data_i),
        .dbg_ready_o(dbg_ready_o),
        .rf_enable_o(rf_enable_o), .rf_reg_write_o(rf_reg_write_o),
        .rf_rd_o(rf_rd_o), .rf_wdata_o(rf_wdata_o), .err_o(err_o)
`ifdef WB_BYPASS_EN
        ,
        .fwd1_valid_o(fwd1_valid_o), .fwd1_data_o(fwd1_data_o),
        .fwd2_valid_o(fwd2_valid_o), .fwd2_data_o(fwd2_data_o)
`endif
    );

    typedef struct {
        logic       alu_v, lsu_v, dbg_v;
        logic [4:0] dbg_rd;
        logic       iv, iwr;
        logic [4:0] ird, rs1, rs2;
        logic       e_alu, e_lsu, e_dbg, e_ird, e_haz;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush_i = 0; issue_valid_i = 0; issue_wr_i = 0;
        issue_rd_i = 0; issue_rs1_i = 0; issue_rs2_i = 0;
        alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
        lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
        dbg_valid_i = 0; dbg_rd_i = 0; dbg_data_i = 0;
    endtask

    // Every drive happens 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        tick();
        issue_valid_i = 1; issue_wr_i = 1; issue_rd_i = rd;
        issue_rs1_i = 0; issue_rs2_i = 0;
        #1 chk($sformatf("issue_rd%0d_ready", rd), issue_ready_o, 1);
        tick();
        issue_valid_i = 0; issue_wr_i = 0; issue_rd_i = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n_i = 0;
        #12;
        chk("rst_rf_enable", rf_enable_o, 0);
        chk("rst_rf_reg_write", rf_reg_write_o, 0);
        chk("rst_rf_rd", rf_rd_o, 0);
        chk("rst_rf_wdata", rf_wdata_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_readies", {alu_ready_o, lsu_ready_o, dbg_ready_o, issue_ready_o}, 0);
        rst_n_i = 1;

        // Scoreboard for the table: busy = {5, 9}
        issue_rd(5);
        issue_rd(9);

        //           alu lsu dbg drd iv iwr ird rs1 rs2 | alu lsu dbg ird haz
        vecs[0]  = '{0, 0, 0, 0,  0, 0, 0,  0,  0,  0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0,  0, 0, 0,  0,  0,  1, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 0, 0,  0, 0, 0,  0,  0,  1, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 0,  0, 0, 0,  0,  0,  0, 1, 0, 0, 0};
        vecs[4]  = '{0, 0, 1, 7,  0, 0, 0,  0,  0,  0, 0, 1, 0, 0};
        vecs[5]  = '{0, 0, 1, 5,  0, 0, 0,  0,  0,  0, 0, 0, 0, 0};
        vecs[6]  = '{1, 0, 1, 7,  0, 0, 0,  0,  0,  1, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0,  1, 0, 0,  5,  0,  0, 0, 0, 0, 1};
        vecs[8]  = '{0, 0, 0, 0,  1, 0, 0,  1,  9,  0, 0, 0, 0, 1};
        vecs[9]  = '{0, 0, 0, 0,  1, 1, 6,  3,  4,  0, 0, 0, 1, 0};
        vecs[10] = '{0, 0, 0, 0,  1, 1, 9,  1,  2,  0, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0,  1, 0, 9,  1,  2,  0, 0, 0, 1, 0};
        vecs[12] = '{0, 1, 1, 3,  1, 1, 0,  0,  0,  0, 1, 0, 1, 0};
        vecs[13] = '{0, 0, 0, 0,  0, 0, 0,  5,  9,  0, 0, 0, 0, 0};

        // Each vector is removed again before the next edge, so the
        // scoreboard and starvation counter stay untouched.
        for (int i = 0; i < 14; i++) begin
            tick();
            alu_valid_i = vecs[i].alu_v; alu_rd_i = 5'd0;
            lsu_valid_i = vecs[i].lsu_v; lsu_rd_i = 5'd0;
            dbg_valid_i = vecs[i].dbg_v; dbg_rd_i = vecs[i].dbg_rd;
            issue_valid_i = vecs[i].iv; issue_wr_i = vecs[i].iwr;
            issue_rd_i = vecs[i].ird; issue_rs1_i = vecs[i].rs1; issue_rs2_i = vecs[i].rs2;
            #1;
            chk($sformatf("vec%0d_alu_ready", i), alu_ready_o, vecs[i].e_alu);
            chk($sformatf("vec%0d_lsu_ready", i), lsu_ready_o, vecs[i].e_lsu);
            chk($sformatf("vec%0d_dbg_ready", i), dbg_ready_o, vecs[i].e_dbg);
            chk($sformatf("vec%0d_issue_ready", i), issue_ready_o, vecs[i].e_ird);
            chk($sformatf("vec%0d_hazard", i), hazard_o, vecs[i].e_haz);
            #1 idle();
        end

        // RAW on rs1=5 resolved by the ALU write-back
        tick();
        alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'hDEADBEEF;
        issue_valid_i = 1; issue_rs1_i = 5;
        #1 chk("raw_alu_ready", alu_ready_o, 1);
        chk("raw_hazard_before", hazard_o, 1);
        tick();
        alu_valid_i = 0;
        #1 chk("raw_rf_enable", rf_enable_o, 1);
        chk("raw_rf_reg_write", rf_reg_write_o, 1);
        chk("raw_rf_rd", rf_rd_o, 5);
        chk("raw_rf_wdata", rf_wdata_o, 32'hDEADBEEF);
        chk("raw_hazard_write_cycle", hazard_o, 1);
        tick();
        #1 chk("raw_hazard_after", hazard_o, 0);
        chk("raw_rf_enable_idle", rf_enable_o, 0);
        chk("raw_rf_rd_hold", rf_rd_o, 5);
        chk("raw_err", err_o, 0);
        idle();

`ifdef WB_BYPASS_EN
        issue_rd(4);
        alu_valid_i = 1; alu_rd_i = 4; alu_data_i = 32'hA5A5A5A5;
        tick();
        alu_valid_i = 0;
        issue_valid_i = 1; issue_rs2_i = 4;
        #1 chk("byp_fwd2_valid", fwd2_valid_o, 1);
        chk("byp_fwd2_data", fwd2_data_o, 32'hA5A5A5A5);
        chk("byp_fwd1_valid", fwd1_valid_o, 0);
        chk("byp_hazard", hazard_o, 0);
        tick();
        idle();
`endif

        // Starvation: ALU (rd 0) and LSU (rd 9, busy) both valid
        tick();
        alu_valid_i = 1; alu_rd_i = 0; alu_data_i = 32'h1234;
        lsu_valid_i = 1; lsu_rd_i = 9; lsu_data_i = 32'h55;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            #1;
            chk($sformatf("starve_c%0d_lsu_ready", c), lsu_ready_o, (c == 4));
            chk($sformatf("starve_c%0d_alu_ready", c), alu_ready_o, (c != 4));
            if (c == 1) begin
                chk("x0_rf_enable", rf_enable_o, 1);
                chk("x0_rf_reg_write", rf_reg_write_o, 0);
                chk("x0_rf_wdata", rf_wdata_o, 32'h1234);
            end
            if (c == 5) begin
                chk("starve_rf_rd", rf_rd_o, 9);
                chk("starve_rf_wdata", rf_wdata_o, 32'h55);
                chk("starve_rf_reg_write", rf_reg_write_o, 1);
            end
        end
        tick();
        idle();
        #1 chk("starve_err", err_o, 0);

        // Debug write blocked while rd 7 is busy
        issue_rd(7);
        dbg_valid_i = 1; dbg_rd_i = 7; dbg_data_i = 32'h77;
        #1 chk("dbg_busy_ready", dbg_ready_o, 0);
        tick();
        lsu_valid_i = 1; lsu_rd_i = 7; lsu_data_i = 32'h700;
        #1 chk("dbg_lsu_ready", lsu_ready_o, 1);
        chk("dbg_blocked_by_lsu", dbg_ready_o, 0);
        tick();
        lsu_valid_i = 0;
        #1 chk("dbg_write_cycle_ready", dbg_ready_o, 0);
        tick();
        #1 chk("dbg_after_clear_ready", dbg_ready_o, 1);
        tick();
        idle();
        #1 chk("dbg_rf_rd", rf_rd_o, 7);
        chk("dbg_rf_wdata", rf_wdata_o, 32'h77);
        chk("dbg_rf_reg_write", rf_reg_write_o, 1);
        chk("dbg_err", err_o, 0);

        // Flush clears busy 3 and 9
        issue_rd(3);
        issue_rd(9);
        issue_valid_i = 1; issue_rs1_i = 3; issue_rs2_i = 9;
        #1 chk("flush_hazard_before", hazard_o, 1);
        tick();
        flush_i = 1; alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'h33;
        #1 chk("flush_alu_ready", alu_ready_o, 0);
        chk("flush_issue_ready", issue_ready_o, 0);
        tick();
        flush_i = 0; alu_valid_i = 0;
        #1 chk("flush_hazard_after", hazard_o, 0);
        chk("flush_rf_enable", rf_enable_o, 0);
        idle();

        // Sticky error on an ALU write to a non-busy rd
        tick();
        alu_valid_i = 1; alu_rd_i = 12; alu_data_i = 32'hC;
        tick();
        idle();
        #1 chk("err_set", err_o, 1);
        chk("err_write_done", rf_reg_write_o, 1);
        tick();
        #1 chk("err_sticky", err_o, 1);

        // Asynchronous reset in the middle of a write
        alu_valid_i = 1; alu_rd_i = 1; alu_data_i = 32'hFFFF;
        tick();
        idle();
        #1 chk("mid_rf_enable", rf_enable_o, 1);
        rst_n_i = 0;
        #1;
        chk("arst_rf_enable", rf_enable_o, 0);
        chk("arst_rf_reg_write", rf_reg_write_o, 0);
        chk("arst_rf_rd", rf_rd_o, 0);
        chk("arst_rf_wdata", rf_wdata_o, 0);
        chk("arst_err", err_o, 0);
        rst_n_i = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Write-back controller for the 32x32 register file. It does three things:
- Arbitrates three write requesters (ALU, LSU load return, debug) onto the single regfile write port.
- Keeps a 32-entry busy scoreboard of pending destination registers.
- Reports RAW/WAW hazards to issue logic.

It sits between execute/memory stages and the regfile's enable_i/reg_write_i/rd_i/write_data_i inputs.

Parameters:
STARVE_LIM, 4, consecutive cycles LSU may wait before it is promoted above ALU (1..15)
CNT_W, 4, width of starvation counter

Ports:
clk_i  input  1  clock
rst_n_i  input  1  asynchronous, active-low reset
flush_i  input  1  synchronous flush: clears scoreboard and drops the pending write
issue_valid_i  input  1  instruction issue request
issue_wr_i  input  1  issuing instruction writes rd
issue_rd_i  input  5  issuing instruction destination
issue_rs1_i  input  5  issuing instruction source 1
issue_rs2_i  input  5  issuing instruction source 2
issue_ready_o  output  1  issue accepted this cycle
hazard_o  output  1  RAW hazard on rs1/rs2
alu_valid_i  input  1  ALU result valid
alu_rd_i  input  5  ALU destination
alu_data_i  input  32  ALU result
alu_ready_o  output  1  ALU result granted
lsu_valid_i  input  1  load data valid
lsu_rd_i  input  5  load destination
lsu_data_i  input  32  load data
lsu_ready_o  output  1  load granted
dbg_valid_i  input  1  debug register write
dbg_rd_i  input  5  debug destination
dbg_data_i  input  32  debug data
dbg_ready_o  output  1  debug granted
rf_enable_o  output  1  to regfile enable_i
rf_reg_write_o  output  1  to regfile reg_write_i
rf_rd_o  output  5  to regfile rd_i
rf_wdata_o  output  32  to regfile write_data_i
err_o  output  1  sticky: ALU/LSU write to a non-busy rd

Behaviour:
- Reset (async):
  - busy[31:0]=0, starve_cnt=0, err_o=0.
  - rf_enable_o=0, rf_reg_write_o=0, rf_rd_o=0, rf_wdata_o=0.
  - All ready outputs are combinational and therefore 0 while valids are 0.
- Scoreboard:
  - busy[0] is hardwired 0.
  - Register x is active when x!=0 and busy[x]=1.
  - hazard_o = issue_valid_i & (active(issue_rs1_i) | active(issue_rs2_i)).
  - issue_ready_o = issue_valid_i & !hazard_o & !(issue_wr_i & active(issue_rd_i)); a busy rd is a WAW stall.
  - When issue_ready_o & issue_wr_i & issue_rd_i!=0, busy[issue_rd_i] sets at the next edge.
- Arbitration (combinational grant, one grant per cycle):
  - Default priority: ALU > LSU > DBG.
  - starve_cnt increments each cycle lsu_valid_i=1 and LSU is not granted, saturating at STARVE_LIM.
  - When starve_cnt==STARVE_LIM, LSU > ALU.
  - starve_cnt clears on an LSU grant or when lsu_valid_i=0.
  - DBG is granted only when ALU and LSU are not valid AND dbg_rd_i is not active. Debug never writes a busy register.
  - A ready output is high only in the same cycle as its valid.
- Write port (1-cycle registered latency): the grant at cycle N drives rf_* during cycle N+1.
  - rf_enable_o=1.
  - rf_reg_write_o = (rd!=0).
  - rf_rd_o and rf_wdata_o carry the granted rd and data.
  - With no grant, rf_enable_o=0 and rf_reg_write_o=0; rf_rd_o and rf_wdata_o hold their values.
- Busy clear:
  - Cleared on the edge where rf_reg_write_o=1 for an ALU/LSU-sourced write. This is the same edge the regfile captures the data.
  - hazard_o drops in the following cycle, when the regfile read data is already valid.
  - Debug writes do not touch the scoreboard.
- Set/clear on the same rd in one cycle cannot occur (issue requires not busy). If it is forced, set wins.
- err_o sets when an ALU/LSU grant targets a non-zero rd whose busy bit is 0. The write is still performed.
- flush_i:
  - At the next edge: busy=0, starve_cnt=0, rf_enable_o=0, rf_reg_write_o=0.
  - Grants are suppressed (all ready=0) in the flush cycle.
  - A write already present on rf_* during the flush cycle still completes.

Optional Feature:
WB_BYPASS_EN:
- Defined:
  - Adds outputs fwd1_valid_o, fwd1_data_o[31:0], fwd2_valid_o, fwd2_data_o[31:0].
  - fwdN_valid_o=1 when rf_reg_write_o=1 and rf_rd_o==issue_rsN_i (rsN!=0); fwdN_data_o=rf_wdata_o.
  - That source is excluded from hazard_o in that cycle.
- Undefined: no forwarding ports; hazard_o exactly as above.

Test Plan:
- Issue rd=5 (issue_wr_i=1), then issue rs1=5 -> hazard_o=1 until ALU writes rd=5 with 0xDEADBEEF. rf_* shows rd=5/0xDEADBEEF one cycle after alu_ready_o. hazard_o=0 the cycle after that.
- ALU and LSU both valid continuously, STARVE_LIM=4 -> LSU waits exactly 4 cycles, is granted on the 5th, starve_cnt returns to 0.
- dbg_valid_i with dbg_rd_i=7 while busy[7]=1 -> dbg_ready_o=0. After the LSU write to rd 7 clears busy, the next cycle gives dbg_ready_o=1.
- ALU write rd=0, data 0x1234 -> rf_enable_o=1, rf_reg_write_o=0, no scoreboard change, err_o=0.
- Busy on rd 3 and 9, assert flush_i -> next cycle busy=0, issue rs1=3 has hazard_o=0. Assert rst_n_i low mid-write -> all rf_* outputs 0 immediately.
- WB_BYPASS_EN defined, rf_* writing rd=4 value 0xA5A5A5A5, issue rs2=4 -> fwd2_valid_o=1, fwd2_data_o=0xA5A5A5A5, hazard_o=0.
